// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the debug-module hart command controller.
//   - run-control state encodings (plain localparams for legacy tools)
//   - abstractcs.cmderror codes
//   - hart_onehot(): one-hot decode of a hart index, zero for non-existent harts
package dm_ctrl_pkg;

   // Widest hart vector the controller supports.
   localparam int unsigned MaxHarts = 32;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StGo     = 2'd1;
   localparam logic [1:0] StResume = 2'd2;
   localparam logic [1:0] StExec   = 2'd3;

   typedef enum logic [2:0] {
      CmdErrNone         = 3'd0,
      CmdErrBusy         = 3'd1,
      CmdErrNotSupported = 3'd2,
      CmdErrException    = 3'd3,
      CmdErrHaltResume   = 3'd4,
      CmdErrBus          = 3'd5,
      CmdErrReserved     = 3'd6,
      CmdErrOther        = 3'd7
   } cmderror_e;

   // One-hot at 'index'; all zeros when index >= nr_harts.
   function automatic logic [MaxHarts-1:0] hart_onehot(input int unsigned index,
                                                       input int unsigned nr_harts);
      logic [MaxHarts-1:0] oh;
      oh = '0;
      for (int unsigned i = 0; i < MaxHarts; i++) begin
         oh[i] = (i == index) && (i < nr_harts);
      end
      return oh;
   endfunction

endpackage

// File: rtl/dm_cmd_watchdog.sv
// Watchdog counter for in-flight abstract commands.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (highest priority), also masks expiry
//   en_i          : count this cycle; the counter returns to zero while disabled
//   expired_o     : high in the LIMIT-th consecutive enabled cycle
module dm_cmd_watchdog #(
   parameter int unsigned LIMIT = 4096
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(LIMIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Zero whenever disabled, so every entry into an enabled run starts from 0.
   // Saturates at CntMax: a run that survives the limit via a legal hand-over
   // expires on its next cycle rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   assign expired_o = en_i && !clr_i && (cnt_q == CntMax);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dm_hart_cmd_ctrl.sv
// Abstract-command / run-control FSM for a multi-hart debug module.
// Latches a target hart, drives one-hot go/resume flags toward debug memory,
// keeps a sticky cmderror with W1C, and aborts hung commands via a watchdog.
//   hartsel_i, cmd_valid_i, unsupported_command_i, cmderror_clr_i : from DMI/CSR block
//   resumereq_i, haltreq_i, ndmreset_i                          : dmcontrol levels
//   going_i, exception_i, halted_i, halted_q_i, resuming_q_i    : from debug memory
//   go_o, resume_o, sel_hart_o                                  : toward debug memory
//   cmderror_o, cmdbusy_o, timeout_o                            : status to abstractcs
module dm_hart_cmd_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int unsigned NR_HARTS       = 4,
   parameter int unsigned HARTSEL_W      = 5,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [HARTSEL_W-1:0] hartsel_i,
   input  logic                 cmd_valid_i,
   input  logic                 unsupported_command_i,
   input  logic                 cmderror_clr_i,
   output logic [2:0]           cmderror_o,
   output logic                 cmdbusy_o,
   output logic [NR_HARTS-1:0]  go_o,
   output logic [NR_HARTS-1:0]  resume_o,
   output logic [HARTSEL_W-1:0] sel_hart_o,
   output logic                 timeout_o,
   input  logic                 going_i,
   input  logic                 exception_i,
   input  logic [NR_HARTS-1:0]  halted_i,
   input  logic [NR_HARTS-1:0]  halted_q_i,
   input  logic [NR_HARTS-1:0]  resuming_q_i,
   input  logic                 resumereq_i,
   input  logic                 haltreq_i,
   input  logic                 ndmreset_i
);

   logic [1:0]           state_q, state_d;
   logic [HARTSEL_W-1:0] sel_q, sel_d;
   logic [2:0]           cmderror_q, cmderror_d;

   logic [NR_HARTS-1:0] hsel_oh, sel_oh;
   logic                hsel_halted, hsel_resuming;
   logic                sel_halted_pulse, sel_resuming;
   logic                wd_en, wd_expired;
   logic                timeout_hit;
   logic                err_busy, err_unsup, err_halt, err_exc;
   logic [2:0]          new_code;

   // Non-existent harts decode to all zeros, which makes them read as not halted.
   assign hsel_oh = NR_HARTS'(hart_onehot(32'(hartsel_i), NR_HARTS));
   assign sel_oh  = NR_HARTS'(hart_onehot(32'(sel_q), NR_HARTS));

   assign hsel_halted      = |(halted_q_i & hsel_oh);
   assign hsel_resuming    = |(resuming_q_i & hsel_oh);
   assign sel_halted_pulse = |(halted_i & sel_oh);
   assign sel_resuming     = |(resuming_q_i & sel_oh);

   // The counter zeroes itself outside GO/EXEC, so every GO entry starts at 0.
   assign wd_en = (state_q == StGo) || (state_q == StExec);

   if (TIMEOUT_CYCLES == 0) begin : g_no_wd
      assign wd_expired = 1'b0;
   end else begin : g_wd
      dm_cmd_watchdog #(
         .LIMIT(TIMEOUT_CYCLES)
      ) u_wd (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .clr_i    (ndmreset_i),
         .en_i     (wd_en),
         .expired_o(wd_expired)
      );
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      timeout_hit = 1'b0;
      err_busy    = 1'b0;
      err_unsup   = 1'b0;
      err_halt    = 1'b0;
      err_exc     = 1'b0;

      case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               if (unsupported_command_i) begin
                  err_unsup = 1'b1;
               end else if (!hsel_halted) begin
                  err_halt = 1'b1;
               end else begin
                  sel_d   = hartsel_i;
                  state_d = StGo;
               end
            end else if (resumereq_i && !haltreq_i && hsel_halted && !hsel_resuming) begin
               sel_d   = hartsel_i;
               state_d = StResume;
            end
         end
         StGo: begin
            err_busy = cmd_valid_i;
            if (going_i) begin
               state_d = StExec;
            end else if (wd_expired) begin
               state_d     = StIdle;
               timeout_hit = 1'b1;
            end
         end
         StExec: begin
            err_busy = cmd_valid_i;
            err_exc  = exception_i;
            if (sel_halted_pulse) begin
               state_d = StIdle;
            end else if (wd_expired) begin
               state_d     = StIdle;
               timeout_hit = 1'b1;
            end
         end
         StResume: begin
            err_busy = cmd_valid_i;
            if (sel_resuming) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // wd_expired is already masked by ndmreset_i, so no timeout fires here.
      if (ndmreset_i) begin
         state_d = StIdle;
         sel_d   = sel_q;
      end
   end

   always_comb begin
      if (err_exc) begin
         new_code = CmdErrException;
      end else if (timeout_hit) begin
         new_code = CmdErrOther;
      end else if (err_unsup) begin
         new_code = CmdErrNotSupported;
      end else if (err_halt) begin
         new_code = CmdErrHaltResume;
      end else if (err_busy) begin
         new_code = CmdErrBusy;
      end else begin
         new_code = CmdErrNone;
      end

      cmderror_d = cmderror_q;
      if (cmderror_clr_i) begin
         cmderror_d = CmdErrNone;
      end
      // A clear in the same cycle frees the register for the new code.
      if ((new_code != CmdErrNone) && ((cmderror_q == CmdErrNone) || cmderror_clr_i)) begin
         cmderror_d = new_code;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         cmderror_q <= CmdErrNone;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cmderror_q <= cmderror_d;
      end
   end

   assign cmderror_o = cmderror_q;
   assign cmdbusy_o  = (state_q != StIdle);
   assign go_o       = (state_q == StGo) ? sel_oh : '0;
   assign resume_o   = (state_q == StResume) ? sel_oh : '0;
   assign sel_hart_o = sel_q;
   assign timeout_o  = timeout_hit;

endmodule

// File: tb/tb_dm_hart_cmd_ctrl.sv
// Self-checking bench for dm_hart_cmd_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_dm_hart_cmd_ctrl;

   localparam int unsigned NrHarts = 4;
   localparam int unsigned SelW    = 5;
   localparam int unsigned Tmo     = 8;
   localparam logic [3:0]  AgeMax  = 4'(Tmo - 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [SelW-1:0] hartsel;
   logic            cmd_valid, unsup, clr;
   logic [2:0]      cmderror_o;
   logic            cmdbusy_o, timeout_o;
   logic [3:0]      go_o, resume_o;
   logic [SelW-1:0] sel_hart_o;
   logic            going, exception;
   logic [3:0]      halted, halted_q, resuming_q;
   logic            resumereq, haltreq, ndmreset;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   dm_hart_cmd_ctrl #(
      .NR_HARTS      (NrHarts),
      .HARTSEL_W     (SelW),
      .TIMEOUT_CYCLES(Tmo)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .hartsel_i            (hartsel),
      .cmd_valid_i          (cmd_valid),
      .unsupported_command_i(unsup),
      .cmderror_clr_i       (clr),
      .cmderror_o           (cmderror_o),
      .cmdbusy_o            (cmdbusy_o),
      .go_o                 (go_o),
      .resume_o             (resume_o),
      .sel_hart_o           (sel_hart_o),
      .timeout_o            (timeout_o),
      .going_i              (going),
      .exception_i          (exception),
      .halted_i             (halted),
      .halted_q_i           (halted_q),
      .resuming_q_i         (resuming_q),
      .resumereq_i          (resumereq),
      .haltreq_i            (haltreq),
      .ndmreset_i           (ndmreset)
   );

   logic [17:0] dut_vec;
   assign dut_vec = {cmdbusy_o, go_o, resume_o, cmderror_o, sel_hart_o, timeout_o};

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 waiting for going, 2 running, 3 waiting for resume ack
   // age  : cycles already spent in the current command (saturates at Tmo-1)
   typedef struct packed {
      logic [1:0]      phase;
      logic [SelW-1:0] sel;
      logic [2:0]      err;
      logic [3:0]      age;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_next(input mstate_t s);
      mstate_t    n;
      bit         exc, tmo, uns, hlt, bsy, req_halted, req_resuming, done;
      logic [2:0] code;
      n = s;
      exc = 0; tmo = 0; uns = 0; hlt = 0; bsy = 0;
      req_halted   = (hartsel < NrHarts) && halted_q[hartsel[1:0]];
      req_resuming = (hartsel < NrHarts) && resuming_q[hartsel[1:0]];
      if (s.phase == 2'd0) begin
         if (cmd_valid) begin
            if (unsup) uns = 1;
            else if (!req_halted) hlt = 1;
            else begin n.phase = 2'd1; n.sel = hartsel; n.age = 4'd0; end
         end else if (resumereq && !haltreq && req_halted && !req_resuming) begin
            n.phase = 2'd3; n.sel = hartsel;
         end
      end else if (s.phase == 2'd3) begin
         bsy = cmd_valid;
         if (resuming_q[s.sel[1:0]]) n.phase = 2'd0;
      end else begin
         bsy  = cmd_valid;
         exc  = (s.phase == 2'd2) && exception;
         done = (s.phase == 2'd1) ? going : halted[s.sel[1:0]];
         if (done) n.phase = (s.phase == 2'd1) ? 2'd2 : 2'd0;
         else if (s.age == AgeMax && !ndmreset) begin tmo = 1; n.phase = 2'd0; end
         n.age = (s.age == AgeMax) ? s.age : s.age + 4'd1;
      end
      if (ndmreset) begin n.phase = 2'd0; n.sel = s.sel; n.age = 4'd0; end
      code = exc ? 3'd3 : tmo ? 3'd7 : uns ? 3'd2 : hlt ? 3'd4 : bsy ? 3'd1 : 3'd0;
      if (code != 3'd0 && (s.err == 3'd0 || clr)) n.err = code;
      else if (clr) n.err = 3'd0;
      return n;
   endfunction

   function automatic logic model_timeout();
      bit stuck;
      stuck = (m.phase == 2'd1 && !going) || (m.phase == 2'd2 && !halted[m.sel[1:0]]);
      return rst_n && stuck && (m.age == AgeMax) && !ndmreset;
   endfunction

   function automatic logic [17:0] model_vec();
      logic [3:0] one;
      logic [3:0] oh;
      one = 4'b0001;
      oh  = one << m.sel;
      return {m.phase != 2'd0, (m.phase == 2'd1) ? oh : 4'b0, (m.phase == 2'd3) ? oh : 4'b0,
              m.err, m.sel, model_timeout()};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_next(m);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      cmd_valid = 0; unsup = 0; clr = 0; going = 0; exception = 0; halted = '0;
      resumereq = 0; haltreq = 0; ndmreset = 0; resuming_q = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 0; hartsel = '0; halted_q = '0; quiet_inputs();
      #3;
      n_cmp++;
      if (dut_vec !== 18'h0) begin
         n_bad++; $display("FAIL reset_held: got %h want 0", dut_vec);
      end
      #14 rst_n = 1;
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
         n_bad++; $display("FAIL reset_released: got %h want %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_cmd_basic();
      halted_q = 4'b0100; hartsel = 5'd2; cmd_valid = 1;
      tick(); cmd_valid = 0;
      n_cmp++;
      if ({cmdbusy_o, go_o, sel_hart_o} !== {1'b1, 4'b0100, 5'd2}) begin
         n_bad++; $display("FAIL cmd_go: got busy=%b go=%b sel=%0d want 1 0100 2",
                           cmdbusy_o, go_o, sel_hart_o);
      end
      going = 1; tick(); going = 0;
      n_cmp++;
      if ({cmdbusy_o, go_o} !== {1'b1, 4'b0000}) begin
         n_bad++; $display("FAIL cmd_exec: got busy=%b go=%b want 1 0000", cmdbusy_o, go_o);
      end
      halted = 4'b0100; tick(); halted = '0;
      n_cmp++;
      if ({cmdbusy_o, cmderror_o} !== {1'b0, 3'd0}) begin
         n_bad++; $display("FAIL cmd_done: got busy=%b err=%0d want 0 0", cmdbusy_o, cmderror_o);
      end
   endtask

   task automatic test_nonexistent();
      hartsel = 5'd5; cmd_valid = 1; tick(); cmd_valid = 0;
      n_cmp++;
      if ({cmderror_o, cmdbusy_o, go_o} !== {3'd4, 1'b0, 4'b0}) begin
         n_bad++; $display("FAIL nonexist_hart: got err=%0d busy=%b go=%b want 4 0 0000",
                           cmderror_o, cmdbusy_o, go_o);
      end
      hartsel = 5'd2; unsup = 1; cmd_valid = 1; tick(); cmd_valid = 0; unsup = 0;
      n_cmp++;
      if ({cmderror_o, cmdbusy_o} !== {3'd4, 1'b0}) begin
         n_bad++; $display("FAIL sticky_err: got err=%0d busy=%b want 4 0", cmderror_o, cmdbusy_o);
      end
      clr = 1; tick(); clr = 0;
      n_cmp++;
      if (cmderror_o !== 3'd0) begin
         n_bad++; $display("FAIL w1c_clear: got err=%0d want 0", cmderror_o);
      end
   endtask

   task automatic test_busy_exception();
      hartsel = 5'd2; cmd_valid = 1; tick(); cmd_valid = 0;
      going = 1; tick(); going = 0;
      cmd_valid = 1; tick(); cmd_valid = 0;
      n_cmp++;
      if ({cmderror_o, cmdbusy_o, go_o} !== {3'd1, 1'b1, 4'b0}) begin
         n_bad++; $display("FAIL busy_err: got err=%0d busy=%b go=%b want 1 1 0000",
                           cmderror_o, cmdbusy_o, go_o);
      end
      clr = 1; tick(); clr = 0;
      exception = 1; tick(); exception = 0;
      n_cmp++;
      if ({cmderror_o, cmdbusy_o} !== {3'd3, 1'b1}) begin
         n_bad++; $display("FAIL exception_err: got err=%0d busy=%b want 3 1", cmderror_o, cmdbusy_o);
      end
      halted = 4'b0100; tick(); halted = '0;
      n_cmp++;
      if (cmdbusy_o !== 1'b0) begin
         n_bad++; $display("FAIL exec_exit: got busy=%b want 0", cmdbusy_o);
      end
   endtask

   task automatic test_timeout();
      clr = 1; tick(); clr = 0;
      hartsel = 5'd2; cmd_valid = 1; tick(); cmd_valid = 0;
      for (int k = 1; k <= int'(Tmo); k++) begin
         n_cmp++;
         if ({timeout_o, go_o} !== {(k == int'(Tmo)), 4'b0100}) begin
            n_bad++; $display("FAIL timeout_cycle%0d: got tmo=%b go=%b want %b 0100",
                              k, timeout_o, go_o, (k == int'(Tmo)));
         end
         if (k < int'(Tmo)) tick();
      end
      tick();
      n_cmp++;
      if ({cmdbusy_o, cmderror_o, timeout_o} !== {1'b0, 3'd7, 1'b0}) begin
         n_bad++; $display("FAIL timeout_abort: got busy=%b err=%0d tmo=%b want 0 7 0",
                           cmdbusy_o, cmderror_o, timeout_o);
      end
   endtask

   task automatic test_resume();
      clr = 1; tick(); clr = 0;
      halted_q = 4'b0010; hartsel = 5'd1; resumereq = 1;
      tick();
      n_cmp++;
      if ({cmdbusy_o, resume_o, go_o} !== {1'b1, 4'b0010, 4'b0}) begin
         n_bad++; $display("FAIL resume_start: got busy=%b res=%b go=%b want 1 0010 0000",
                           cmdbusy_o, resume_o, go_o);
      end
      tick();
      n_cmp++;
      if (resume_o !== 4'b0010) begin
         n_bad++; $display("FAIL resume_hold: got res=%b want 0010", resume_o);
      end
      resuming_q = 4'b0010; tick();
      n_cmp++;
      if ({cmdbusy_o, resume_o} !== {1'b0, 4'b0}) begin
         n_bad++; $display("FAIL resume_ack: got busy=%b res=%b want 0 0000", cmdbusy_o, resume_o);
      end
      resuming_q = '0; haltreq = 1; tick(); tick();
      n_cmp++;
      if ({cmdbusy_o, resume_o} !== {1'b0, 4'b0}) begin
         n_bad++; $display("FAIL resume_blocked: got busy=%b res=%b want 0 0000",
                           cmdbusy_o, resume_o);
      end
      resumereq = 0; haltreq = 0;
   endtask

   task automatic test_ndmreset();
      halted_q = 4'b0100; hartsel = 5'd2; clr = 1; cmd_valid = 1; tick(); clr = 0; cmd_valid = 0;
      going = 1; tick(); going = 0;
      exception = 1; tick(); exception = 0;
      ndmreset = 1; tick(); ndmreset = 0;
      n_cmp++;
      if ({cmdbusy_o, go_o, cmderror_o, sel_hart_o} !== {1'b0, 4'b0, 3'd3, 5'd2}) begin
         n_bad++; $display("FAIL ndmreset: got busy=%b go=%b err=%0d sel=%0d want 0 0000 3 2",
                           cmdbusy_o, go_o, cmderror_o, sel_hart_o);
      end
   endtask

   task automatic test_async_reset();
      hartsel = 5'd2; cmd_valid = 1; tick(); cmd_valid = 0;
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if (dut_vec !== 18'h0) begin
         n_bad++; $display("FAIL async_reset: got %h want 0", dut_vec);
      end
      @(negedge clk);
      #2 rst_n = 1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         hartsel    = 5'($urandom_range(0, 7));
         cmd_valid  = ($urandom_range(0, 7) == 0);
         unsup      = ($urandom_range(0, 3) == 0);
         clr        = ($urandom_range(0, 15) == 0);
         going      = ($urandom_range(0, 5) == 0);
         exception  = ($urandom_range(0, 15) == 0);
         halted     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         halted_q   = 4'($urandom);
         resuming_q = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
         resumereq  = ($urandom_range(0, 2) == 0);
         haltreq    = ($urandom_range(0, 3) == 0);
         ndmreset   = ($urandom_range(0, 39) == 0);
         #1;
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, model_vec());
         end
      end
      @(negedge clk);
      quiet_inputs();
   endtask

   initial begin
      test_reset();
      test_cmd_basic();
      test_nonexistent();
      test_busy_exception();
      test_timeout();
      test_resume();
      test_ndmreset();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dm_hart_cmd_ctrl.md
Name: dm_hart_cmd_ctrl

Overview:
- Next-generation debug-module command/run-control FSM serving NR_HARTS harts instead of one.
- Selects a target hart and drives per-hart one-hot go/resume strobes toward debug memory.
- Keeps a sticky RISC-V-style cmderror register with write-1-to-clear, detects busy violations and aborts hung commands with a watchdog.
- Sits between the DMI/CSR register block and the debug memory flag logic.

Parameters:
- NR_HARTS, 4, number of harts controlled (1..32).
- HARTSEL_W, 5, width of hart select field; hartsel values >= NR_HARTS are non-existent harts.
- TIMEOUT_CYCLES, 4096, watchdog limit for GO/EXEC; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- hartsel_i  in  HARTSEL_W  hart selected by dmcontrol.
- cmd_valid_i  in  1  one-cycle pulse: abstract command written.
- unsupported_command_i  in  1  command type not supported; qualified by cmd_valid_i.
- cmderror_clr_i  in  1  pulse: clear cmderror (W1C from abstractcs).
- cmderror_o  out  3  sticky error code: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume, 7 other/timeout.
- cmdbusy_o  out  1  high whenever state != IDLE.
- go_o  out  NR_HARTS  one-hot go flag to the latched hart.
- resume_o  out  NR_HARTS  one-hot resume flag to the latched hart.
- sel_hart_o  out  HARTSEL_W  latched hart index.
- timeout_o  out  1  one-cycle pulse when the watchdog aborts.
- going_i  in  1  debug memory reports that the hart fetched the go flag.
- exception_i  in  1  hart took an exception in debug mode.
- halted_i  in  NR_HARTS  per-hart pulse: hart re-entered park loop.
- halted_q_i  in  NR_HARTS  per-hart level: hart halted.
- resuming_q_i  in  NR_HARTS  per-hart level: hart acknowledged resume.
- resumereq_i  in  1  dmcontrol resume request (level).
- haltreq_i  in  1  dmcontrol halt request (level).
- ndmreset_i  in  1  non-debug-module reset.

Behaviour:
- Reset: state IDLE, sel_q 0, counter 0, cmderror_o 0, cmdbusy_o 0, go_o 0, resume_o 0, timeout_o 0, sel_hart_o 0.
- Outputs derive only from registers: go_o = (state_q==GO) one-hot at sel_q; resume_o = (state_q==RESUME) one-hot at sel_q; cmdbusy_o = (state_q!=IDLE).
- Hart is valid when hartsel_i < NR_HARTS; hsel_halted = valid && halted_q_i[hartsel_i].
- IDLE, on cmd_valid_i:
  - unsupported: error 2, stay IDLE.
  - else if !hsel_halted: error 4, stay IDLE.
  - else: latch sel_q <= hartsel_i, go to GO next cycle.
- IDLE, no cmd_valid_i, with resumereq_i && !haltreq_i && hsel_halted && !resuming_q_i[hartsel_i]: latch sel_q, go to RESUME. A command in the same cycle wins; resume is re-evaluated later because resumereq_i is a level.
- GO: wait for going_i, then go to EXEC. go_o is asserted for every GO cycle.
- EXEC: wait for halted_i[sel_q], then go to IDLE. exception_i records error 3 but does not leave EXEC.
- RESUME: wait for resuming_q_i[sel_q], then go to IDLE. No watchdog in RESUME.
- cmd_valid_i outside IDLE: error 1; the command is ignored and the state is unchanged.
- Watchdog:
  - Counter clears on entry to GO and increments each GO/EXEC cycle.
  - Reaching TIMEOUT_CYCLES-1 without exit forces IDLE, records error 7 and pulses timeout_o.
  - A legal exit in the same cycle takes precedence over the timeout.
- Sticky error rules:
  - A new code is written only if cmderror_o==0.
  - Same-cycle source priority: exception(3) > timeout(7) > not-supported(2) > halt/resume(4) > busy(1).
  - cmderror_clr_i clears the register; if a new error arrives in the same cycle, the new code is stored.
- ndmreset_i: next state IDLE, counter cleared, go_o/resume_o drop next cycle. cmderror_o is preserved and sel_q is unchanged.
- Latency: cmd_valid_i to go_o is 1 cycle; halted_i to cmdbusy_o low is 1 cycle.

Decomposition:
- Shared package dm_ctrl_pkg holds:
  - state encodings IDLE=0, GO=1, RESUME=2, EXEC=3;
  - cmderror codes 0..7;
  - function hart_onehot(index, NR_HARTS).
- One natural sub-module, dm_cmd_watchdog: counter with clear, enable and expiry pulse; it is tied off when TIMEOUT_CYCLES=0.

Test Plan:
- NR_HARTS=4, halted_q_i=4'b0100, hartsel_i=2, cmd_valid_i -> go_o=4'b0100 next cycle; after going_i then halted_i[2] -> IDLE, cmderror_o=0.
- hartsel_i=5 (non-existent) with cmd_valid_i -> cmderror_o=4, state stays IDLE, go_o=0. A second cmd with unsupported=1 keeps cmderror_o=4 (sticky). cmderror_clr_i then sets 0.
- cmd_valid_i during EXEC -> cmderror_o=1, go_o unchanged. Exception in EXEC with error already clear -> cmderror_o=3.
- TIMEOUT_CYCLES=8, GO without going_i -> timeout_o pulses on the 8th GO cycle, cmderror_o=7, cmdbusy_o=0 next cycle.
- resumereq_i=1, hart 1 halted, hartsel_i=1 -> resume_o=4'b0010 until resuming_q_i[1]=1, then IDLE. The same setup with haltreq_i=1 -> stays IDLE.
- ndmreset_i in EXEC with cmderror_o=3 -> IDLE next cycle, cmderror_o still 3. Async rst_ni low mid-GO -> all outputs 0 immediately.
